// File: rtl/rr_reg_pkg.sv
// Shared constants and helpers for the round-robin register write arbiter.
package rr_reg_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;

  localparam int                 STALL_W   = 8;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // $clog2 returns 0 for 1; every index/addr field needs at least one bit.
  function automatic int rr_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_reg_write_arbiter_if.sv
// Requester/read-port bundle between the write agents and the arbitrated register bank.
interface rr_reg_write_arbiter_if import rr_reg_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH
);
  localparam int ADDR_W = rr_clog2(DEPTH);
  localparam int ID_W   = rr_clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [ADDR_W-1:0]         rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic [ID_W-1:0]           grant_id;
  logic                      addr_err;
  logic [STALL_W-1:0]        stall_cnt;

  modport master (
    output req_valid, req_addr, req_data, rd_addr,
    input  req_ready, rd_data, grant_id, addr_err, stall_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, rd_addr,
    output req_ready, rd_data, grant_id, addr_err, stall_cnt
  );
endinterface

// File: rtl/rr_arbiter_core.sv
// Round-robin grant: rotate requests by the pointer, pick the lowest set bit, map back.
module rr_arbiter_core import rr_reg_pkg::*; #(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = rr_clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int                   k_sel, idx;

  always_comb begin
    // Doubling the vector makes the rotate a plain right shift.
    dbl   = {req_valid, req_valid} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    k_sel = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        k_sel = k;
      end
    end
    idx = int'(ptr) + k_sel;
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    grant_id = ID_W'(idx);
    grant    = '0;
    if (found && rst_n) grant[grant_id] = 1'b1;
    ptr_nxt  = (idx == NUM_REQ - 1) ? '0 : ID_W'(idx + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/rr_reg_write_arbiter.sv
// Register bank shared by NUM_REQ writers via round-robin grant, with one combinational read port.
module rr_reg_write_arbiter import rr_reg_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_reg_write_arbiter_if.slave  bus
);
  localparam int ADDR_W = rr_clog2(DEPTH);
  localparam int ID_W   = rr_clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic               accept, in_range, stalled;
  logic [DEPTH-1:0]   we;
  logic [WIDTH-1:0]   regs [DEPTH];

  rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_id  (gid)
  );

  assign bus.req_ready = grant;
  assign bus.grant_id  = gid;
  assign accept        = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(gid) == i) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Out-of-range writes still complete the handshake; they just enable nothing.
  assign in_range = int'(sel_addr) < DEPTH;

  always_comb begin
    we = '0;
    for (int e = 0; e < DEPTH; e++) we[e] = accept && in_range && (int'(sel_addr) == e);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) regs[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) if (we[e]) regs[e] <= sel_data;
    end
  end

  // No write bypass: a same-cycle read of the target sees the old value.
  always_comb begin
    bus.rd_data = '0;
    for (int e = 0; e < DEPTH; e++) if (int'(bus.rd_addr) == e) bus.rd_data = regs[e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.addr_err <= 1'b0;
    else        bus.addr_err <= accept && !in_range;
  end

  assign stalled = |(bus.req_valid & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    bus.stall_cnt <= '0;
    else if (stalled && bus.stall_cnt != STALL_MAX) bus.stall_cnt <= bus.stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Bench for rr_reg_write_arbiter: DEPTH=4 and DEPTH=3 instances share stimulus and a reference model.
module tb_rr_reg_write_arbiter;
  import rr_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] valid;
  logic [7:0] addr_p;
  logic [31:0] data_p;
  logic [1:0] rd_a;

  always #5 clk = ~clk;

  rr_reg_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .DEPTH(4)) bus4 ();
  rr_reg_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .DEPTH(3)) bus3 ();

  assign bus4.req_valid = valid;
  assign bus4.req_addr  = addr_p;
  assign bus4.req_data  = data_p;
  assign bus4.rd_addr   = rd_a;
  assign bus3.req_valid = valid;
  assign bus3.req_addr  = addr_p;
  assign bus3.req_data  = data_p;
  assign bus3.rd_addr   = rd_a;

  rr_reg_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  rr_reg_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Reference state: register contents per instance, shared pointer and stall count.
  int         depth_m [2] = '{4, 3};
  logic [7:0] regs_m [2][4];
  bit         err_m [2];
  int         ptr_m, stall_m, last_g;
  int         nvec = 0, nmis = 0;

  typedef struct {
    logic [3:0] v;
    logic [1:0] ra;
    logic [3:0] ready;
    logic [7:0] rd;
    logic [7:0] stall;
  } vec_t;
  vec_t tbl [9];

  bit         pv [4];
  logic [1:0] pa [4];
  logic [7:0] pd [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      err_m[d] = 1'b0;
      for (int a = 0; a < 4; a++) regs_m[d][a] = 8'h00;
    end
    ptr_m   = 0;
    stall_m = 0;
  endtask

  task automatic check_outputs(input string tag);
    int g;
    logic [3:0] m;
    logic [7:0] e4, e3;
    g  = rst_n ? pick(valid, ptr_m) : -1;
    m  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    e4 = regs_m[0][rd_a];
    e3 = (int'(rd_a) < 3) ? regs_m[1][rd_a] : 8'h00;
    chk({tag, ".ready4"}, 32'(bus4.req_ready), 32'(m));
    chk({tag, ".ready3"}, 32'(bus3.req_ready), 32'(m));
    if (g >= 0) begin
      chk({tag, ".gid4"}, 32'(bus4.grant_id), 32'(g));
      chk({tag, ".gid3"}, 32'(bus3.grant_id), 32'(g));
    end
    chk({tag, ".rd4"},    32'(bus4.rd_data),   32'(e4));
    chk({tag, ".rd3"},    32'(bus3.rd_data),   32'(e3));
    chk({tag, ".err4"},   32'(bus4.addr_err),  32'(err_m[0]));
    chk({tag, ".err3"},   32'(bus3.addr_err),  32'(err_m[1]));
    chk({tag, ".stall4"}, 32'(bus4.stall_cnt), 32'(stall_m));
    chk({tag, ".stall3"}, 32'(bus3.stall_cnt), 32'(stall_m));
  endtask

  // Called just after inputs change at a negedge; returns at the next negedge.
  task automatic tick(input string tag);
    int g, a;
    logic [3:0] m;
    #1;
    check_outputs(tag);
    g = rst_n ? pick(valid, ptr_m) : -1;
    m = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    @(posedge clk);
    if (rst_n) begin
      for (int d = 0; d < 2; d++) err_m[d] = 1'b0;
      if (g >= 0) begin
        a = int'(addr_p[g*2 +: 2]);
        for (int d = 0; d < 2; d++) begin
          if (a < depth_m[d]) regs_m[d][a] = data_p[g*8 +: 8];
          else                err_m[d] = 1'b1;
        end
        ptr_m = (g + 1) % 4;
      end
      if ((valid & ~m) != 4'b0000 && stall_m < 255) stall_m++;
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    valid  = 4'b1111;
    addr_p = {2'd3, 2'd2, 2'd1, 2'd0};
    data_p = {8'h13, 8'h12, 8'h11, 8'h10};
    rd_a   = 2'd0;
    model_reset();

    tbl[0] = '{4'b1111, 2'd0, 4'b0001, 8'h00, 8'd0};
    tbl[1] = '{4'b1111, 2'd0, 4'b0010, 8'h10, 8'd1};
    tbl[2] = '{4'b1111, 2'd1, 4'b0100, 8'h11, 8'd2};
    tbl[3] = '{4'b1111, 2'd2, 4'b1000, 8'h12, 8'd3};
    tbl[4] = '{4'b1111, 2'd3, 4'b0001, 8'h13, 8'd4};
    tbl[5] = '{4'b1111, 2'd0, 4'b0010, 8'h10, 8'd5};
    tbl[6] = '{4'b1111, 2'd1, 4'b0100, 8'h11, 8'd6};
    tbl[7] = '{4'b1111, 2'd2, 4'b1000, 8'h12, 8'd7};
    tbl[8] = '{4'b0000, 2'd3, 4'b0000, 8'h13, 8'd8};

    // Held in reset with every requester valid.
    @(negedge clk);
    #1;
    chk("rst.ready4", 32'(bus4.req_ready), 32'h0);
    chk("rst.ready3", 32'(bus3.req_ready), 32'h0);
    chk("rst.stall",  32'(bus4.stall_cnt), 32'h0);
    for (int a = 0; a < 3; a++) begin
      rd_a = 2'(a);
      #1 chk($sformatf("rst.rd%0d", a), 32'(bus4.rd_data), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness and write/read table, starting in the reset-release cycle.
    for (int r = 0; r < 9; r++) begin
      valid = tbl[r].v;
      rd_a  = tbl[r].ra;
      #1;
      chk($sformatf("tbl%0d.ready", r), 32'(bus4.req_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d.rd", r),    32'(bus4.rd_data),   32'(tbl[r].rd));
      chk($sformatf("tbl%0d.stall", r), 32'(bus4.stall_cnt), 32'(tbl[r].stall));
      tick($sformatf("tbl%0d", r));
    end

    // Async reset asserted between edges, during a burst.
    valid = 4'b1111;
    tick("burst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.ready", 32'(bus4.req_ready), 32'h0);
    chk("arst.stall", 32'(bus4.stall_cnt), 32'h0);
    chk("arst.err3",  32'(bus3.addr_err),  32'h0);
    @(posedge clk);
    for (int a = 0; a < 4; a++) begin
      rd_a = 2'(a);
      #1 chk($sformatf("arst.rd%0d", a), 32'(bus4.rd_data), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst.release", 32'(bus4.req_ready), 32'h1);
    valid = 4'b0000;
    tick("idle");

    // Write then read the same address: old value this cycle, new value next.
    valid  = 4'b0001;
    addr_p = {2'd0, 2'd0, 2'd0, 2'd2};
    data_p = {8'h00, 8'h00, 8'h00, 8'hA5};
    rd_a   = 2'd2;
    #1 chk("wr.rd_old", 32'(bus4.rd_data), 32'h00);
    tick("wr");
    valid = 4'b0000;
    #1 chk("wr.rd_new", 32'(bus4.rd_data), 32'hA5);
    rd_a = 2'd0;
    #1 chk("wr.rd0", 32'(bus4.rd_data), 32'h00);
    tick("wr_chk0");
    rd_a = 2'd1;
    #1 chk("wr.rd1", 32'(bus4.rd_data), 32'h00);
    rd_a = 2'd3;
    #1 chk("wr.rd3", 32'(bus4.rd_data), 32'h00);
    tick("wr_chk1");

    // Advance pointer to 2, then two requesters target address 1.
    valid  = 4'b0010;
    addr_p = {2'd0, 2'd0, 2'd3, 2'd0};
    data_p = {8'h00, 8'h00, 8'h5C, 8'h00};
    tick("ptr2");
    valid  = 4'b1010;
    addr_p = {2'd1, 2'd0, 2'd1, 2'd0};
    data_p = {8'h33, 8'h00, 8'h11, 8'h00};
    rd_a   = 2'd1;
    #1 chk("same.first", 32'(bus4.req_ready), 32'h8);
    tick("same0");
    valid = 4'b0010;
    #1 chk("same.second", 32'(bus4.req_ready), 32'h2);
    chk("same.rd33", 32'(bus4.rd_data), 32'h33);
    tick("same1");
    valid = 4'b0000;
    #1 chk("same.final", 32'(bus4.rd_data), 32'h11);
    tick("same2");

    // Out-of-range write on the DEPTH=3 instance.
    valid  = 4'b0100;
    addr_p = {2'd0, 2'd3, 2'd0, 2'd0};
    data_p = {8'h00, 8'hFF, 8'h00, 8'h00};
    rd_a   = 2'd3;
    #1 chk("err.ready", 32'(bus3.req_ready), 32'h4);
    tick("err0");
    valid = 4'b0000;
    #1 chk("err.pulse", 32'(bus3.addr_err), 32'h1);
    chk("err.no_pulse4", 32'(bus4.addr_err), 32'h0);
    tick("err1");
    #1 chk("err.clear", 32'(bus3.addr_err), 32'h0);
    tick("err2");

    // Randomised traffic with requesters holding until accepted.
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 50) begin
          pv[i] = 1'b1;
          pa[i] = 2'($urandom_range(0, 3));
          pd[i] = 8'($urandom_range(0, 255));
        end
        valid[i]         = pv[i];
        addr_p[i*2 +: 2] = pa[i];
        data_p[i*8 +: 8] = pd[i];
      end
      rd_a = 2'($urandom_range(0, 3));
      tick("rand");
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    // Drive enough contention to reach saturation.
    valid = 4'b1111;
    for (int c = 0; c < 260; c++) tick("sat");
    #1;
    chk("sat.stall4", 32'(bus4.stall_cnt), 32'd255);
    chk("sat.stall3", 32'(bus3.stall_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
